mc_ctrl: RTL and testbench

// - Multi-cycle MIPS control FSM. It is the initiator side of the ALU interface: it issues ALUOp and operand selects, and consumes ALU_Zero.
// - Sequences the shared-datapath phases FETCH/DECODE/EXE/MEM/WB, and drives the PC, IR, memory and register-file enables.
// - Subset: addu, subu, and, or, ori, lui, lw, sw, beq, j (+jal optional).

---
 rtl/mc_ctrl_pkg.sv | 80 ++++++++
 rtl/mc_ctrl_if.sv | 34 +++
 rtl/mc_aluop_dec.sv | 20 ++
 rtl/mc_ctrl.sv | 166 ++++++++++++++++
 tb/tb_mc_ctrl.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared MIPS definitions for the multi-cycle controller and its ALU: opcodes, functs,
// ALUOp/select codes, state encodings and the registered control-word layout.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_OR   = 2'b11;

    localparam logic       SRCA_PC  = 1'b0;
    localparam logic       SRCA_REG = 1'b1;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFS = 2'b11;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_HI   = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    typedef enum logic [3:0] {
        ST_RST     = 4'd0,
        ST_FETCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_MEM_ADR = 4'd3,
        ST_MEM_RD  = 4'd4,
        ST_MEM_WB  = 4'd5,
        ST_MEM_WR  = 4'd6,
        ST_EXE_R   = 4'd7,
        ST_R_WB    = 4'd8,
        ST_EXE_I   = 4'd9,
        ST_I_WB    = 4'd10,
        ST_BRANCH  = 4'd11,
        ST_JUMP    = 4'd12,
        ST_JAL     = 4'd13
    } state_t;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] ext_op;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       done;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and ALU flag in, select/enable controls out.
interface mc_ctrl_if #(
    parameter int ST_W = 4
);
    logic [5:0]      Op;
    logic [5:0]      Funct;
    logic            ALU_Zero;
    logic [1:0]      ALUOp;
    logic            ALUSrcA;
    logic [1:0]      ALUSrcB;
    logic [1:0]      ExtOp;
    logic            PCWrite;
    logic [1:0]      PCSrc;
    logic            IRWrite;
    logic            MemWrite;
    logic            RegWrite;
    logic [1:0]      RegDst;
    logic [1:0]      MemtoReg;
    logic            instr_done;
    logic            illegal;
    logic [ST_W-1:0] state_o;

    modport master (
        input  Op, Funct, ALU_Zero,
        output ALUOp, ALUSrcA, ALUSrcB, ExtOp, PCWrite, PCSrc, IRWrite,
               MemWrite, RegWrite, RegDst, MemtoReg, instr_done, illegal, state_o
    );

    modport slave (
        output Op, Funct, ALU_Zero,
        input  ALUOp, ALUSrcA, ALUSrcB, ExtOp, PCWrite, PCSrc, IRWrite,
               MemWrite, RegWrite, RegDst, MemtoReg, instr_done, illegal, state_o
    );
endinterface

// File: rtl/mc_aluop_dec.sv
// R-type funct decoder: ALU operation plus a legality flag for the supported subset.
module mc_aluop_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [1:0] alu_op,
    output logic       legal
);
    always_comb begin
        alu_op = ALU_ADD;
        legal  = 1'b1;
        case (funct)
            FN_ADDU: alu_op = ALU_ADD;
            FN_SUBU: alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            default: legal  = 1'b0;
        endcase
    end
endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM with registered Moore outputs.
// Optional jal support is enabled by defining MC_CTRL_JAL_EN.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int ST_W = 4
) (
    input logic      clk,
    input logic      rst_n,
    mc_ctrl_if.master bus
);
    logic [1:0] fn_alu_op;
    logic       fn_legal;
    state_t     state;
    state_t     state_nxt;
    ctrl_t      ctrl;

    mc_aluop_dec u_aluop_dec (
        .funct  (bus.Funct),
        .alu_op (fn_alu_op),
        .legal  (fn_legal)
    );

    function automatic state_t next_state(input state_t cur, input logic [5:0] opc,
                                          input logic fn_ok);
        case (cur)
            ST_RST:     return ST_FETCH;
            ST_FETCH:   return ST_DECODE;
            ST_DECODE: begin
                case (opc)
                    OP_LW, OP_SW:   return ST_MEM_ADR;
                    OP_RTYPE:       return fn_ok ? ST_EXE_R : ST_FETCH;
                    OP_ORI, OP_LUI: return ST_EXE_I;
                    OP_BEQ:         return ST_BRANCH;
                    OP_J:           return ST_JUMP;
`ifdef MC_CTRL_JAL_EN
                    OP_JAL:         return ST_JAL;
`endif
                    default:        return ST_FETCH;
                endcase
            end
            ST_MEM_ADR: return (opc == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:  return ST_MEM_WB;
            ST_EXE_R:   return ST_R_WB;
            ST_EXE_I:   return ST_I_WB;
            default:    return ST_FETCH;
        endcase
    endfunction

    // Control word for the state being entered; IR is already valid by DECODE, so
    // Op/Funct-dependent fields (EXE_R ALUOp, EXE_I ExtOp) can be latched on entry.
    function automatic ctrl_t ctrl_for(input state_t st, input logic [5:0] opc,
                                       input logic [1:0] fn_alu);
        ctrl_t c;
        c = '0;
        case (st)
            ST_FETCH: begin
                c.src_a    = SRCA_PC;
                c.src_b    = SRCB_FOUR;
                c.alu_op   = ALU_ADD;
                c.pc_src   = PCSRC_ALU;
                c.pc_write = 1'b1;
                c.ir_write = 1'b1;
            end
            ST_DECODE: begin
                c.src_a  = SRCA_PC;
                c.src_b  = SRCB_BOFS;
                c.alu_op = ALU_ADD;
            end
            ST_MEM_ADR: begin
                c.src_a  = SRCA_REG;
                c.src_b  = SRCB_IMM;
                c.ext_op = EXT_SIGN;
                c.alu_op = ALU_ADD;
            end
            ST_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = DST_RT;
                c.mem_to_reg = M2R_MDR;
                c.done       = 1'b1;
            end
            ST_MEM_WR: begin
                c.mem_write = 1'b1;
                c.done      = 1'b1;
            end
            ST_EXE_R: begin
                c.src_a  = SRCA_REG;
                c.src_b  = SRCB_REG;
                c.alu_op = fn_alu;
            end
            ST_R_WB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = DST_RD;
                c.mem_to_reg = M2R_ALUOUT;
                c.done       = 1'b1;
            end
            // lui relies on rs=$0: OR with the imm<<16 extension yields the result.
            ST_EXE_I: begin
                c.src_a  = SRCA_REG;
                c.src_b  = SRCB_IMM;
                c.alu_op = ALU_OR;
                c.ext_op = (opc == OP_LUI) ? EXT_HI : EXT_ZERO;
            end
            ST_I_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = DST_RT;
                c.done      = 1'b1;
            end
            ST_BRANCH: begin
                c.src_a  = SRCA_REG;
                c.src_b  = SRCB_REG;
                c.alu_op = ALU_SUB;
                c.pc_src = PCSRC_ALUOUT;
                c.done   = 1'b1;
            end
            ST_JUMP: begin
                c.pc_src   = PCSRC_JUMP;
                c.pc_write = 1'b1;
                c.done     = 1'b1;
            end
`ifdef MC_CTRL_JAL_EN
            ST_JAL: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = DST_RA;
                c.mem_to_reg = M2R_PC;
                c.pc_src     = PCSRC_JUMP;
                c.pc_write   = 1'b1;
                c.done       = 1'b1;
            end
`endif
            default: c = '0;
        endcase
        return c;
    endfunction

    assign state_nxt = next_state(state, bus.Op, fn_legal);

    // Async reset clears state and every registered enable at once, aborting any write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RST;
            ctrl  <= '0;
        end else begin
            state <= state_nxt;
            ctrl  <= ctrl_for(state_nxt, bus.Op, fn_alu_op);
        end
    end

    // An unsupported instruction is the only way DECODE falls straight back to FETCH.
    assign bus.illegal    = (state == ST_DECODE) && (state_nxt == ST_FETCH);
    assign bus.instr_done = ctrl.done | bus.illegal;

    assign bus.ALUOp    = ctrl.alu_op;
    assign bus.ALUSrcA  = ctrl.src_a;
    assign bus.ALUSrcB  = ctrl.src_b;
    assign bus.ExtOp    = ctrl.ext_op;
    assign bus.PCWrite  = ctrl.pc_write | ((state == ST_BRANCH) & bus.ALU_Zero);
    assign bus.PCSrc    = ctrl.pc_src;
    assign bus.IRWrite  = ctrl.ir_write;
    assign bus.MemWrite = ctrl.mem_write;
    assign bus.RegWrite = ctrl.reg_write;
    assign bus.RegDst   = ctrl.reg_dst;
    assign bus.MemtoReg = ctrl.mem_to_reg;
    assign bus.state_o  = ST_W'(state);

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-instruction vector table plus reset/branch corner sequences.
module tb_mc_ctrl;
    import mc_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mc_ctrl_if #(.ST_W(4)) bus();
    mc_ctrl #(.ST_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int applied = 0;
    int miscompares = 0;

    typedef struct {
        string            name;
        logic [5:0]       op;
        logic [5:0]       funct;
        logic             zero;
        int               len;
        logic [4:0][3:0]  path;
        logic [4:0][18:0] outs;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [18:0] pk(input logic [1:0] alu_op, input logic src_a,
        input logic [1:0] src_b, input logic [1:0] ext, input logic pcw,
        input logic [1:0] pcsrc, input logic irw, input logic memw, input logic regw,
        input logic [1:0] dst, input logic [1:0] m2r, input logic done, input logic ill);
        return {alu_op, src_a, src_b, ext, pcw, pcsrc, irw, memw, regw, dst, m2r, done, ill};
    endfunction

    function automatic logic [18:0] observed();
        return {bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB, bus.ExtOp, bus.PCWrite, bus.PCSrc,
                bus.IRWrite, bus.MemWrite, bus.RegWrite, bus.RegDst, bus.MemtoReg,
                bus.instr_done, bus.illegal};
    endfunction

    task automatic check(input string name, input logic [3:0] exp_st, input logic [18:0] exp_out);
        logic [18:0] got;
        got = observed();
        applied++;
        if (bus.state_o !== exp_st || got !== exp_out) begin
            miscompares++;
            $display("FAIL %s: state=%0d outs=%05h, expected state=%0d outs=%05h",
                     name, bus.state_o, got, exp_st, exp_out);
        end
    endtask

    task automatic add(input string name, input logic [5:0] op, input logic [5:0] funct,
        input logic zero, input int len,
        input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
        input logic [3:0] s3, input logic [3:0] s4,
        input logic [18:0] o0, input logic [18:0] o1, input logic [18:0] o2,
        input logic [18:0] o3, input logic [18:0] o4);
        vec_t v;
        v.name  = name;
        v.op    = op;
        v.funct = funct;
        v.zero  = zero;
        v.len   = len;
        v.path  = {s4, s3, s2, s1, s0};
        v.outs  = {o4, o3, o2, o1, o0};
        tbl.push_back(v);
    endtask

    logic [18:0] e_f, e_d, e_dill, e_ma, e_mr, e_mwb, e_mwr, e_rwb, e_iwb, e_jmp, e_jal;
    logic [18:0] e_er00, e_er01, e_er10, e_er11, e_ei_ori, e_ei_lui, e_br1, e_br0;

    initial begin
        bus.Op       = 6'h00;
        bus.Funct    = 6'h00;
        bus.ALU_Zero = 1'b0;

        //            aluop  A     srcB   ext    pcw   pcsrc  irw   memw  regw  dst    m2r    done  ill
        e_f      = pk(2'b00, 1'b0, 2'b01, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        e_d      = pk(2'b00, 1'b0, 2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        e_dill   = pk(2'b00, 1'b0, 2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1);
        e_ma     = pk(2'b00, 1'b1, 2'b10, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        e_mr     = '0;
        e_mwb    = pk(2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b1, 1'b0);
        e_mwr    = pk(2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
        e_er00   = pk(2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        e_er01   = pk(2'b01, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        e_er10   = pk(2'b10, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        e_er11   = pk(2'b11, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        e_rwb    = pk(2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 1'b1, 1'b0);
        e_ei_ori = pk(2'b11, 1'b1, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        e_ei_lui = pk(2'b11, 1'b1, 2'b10, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        e_iwb    = pk(2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0);
        e_br1    = pk(2'b01, 1'b1, 2'b00, 2'b00, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
        e_br0    = pk(2'b01, 1'b1, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
        e_jmp    = pk(2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
        e_jal    = pk(2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 1'b1, 1'b0);

        add("addu", 6'h00, 6'h21, 1'b0, 4, ST_FETCH, ST_DECODE, ST_EXE_R, ST_R_WB, ST_RST,
            e_f, e_d, e_er00, e_rwb, '0);
        add("subu", 6'h00, 6'h23, 1'b0, 4, ST_FETCH, ST_DECODE, ST_EXE_R, ST_R_WB, ST_RST,
            e_f, e_d, e_er01, e_rwb, '0);
        add("and",  6'h00, 6'h24, 1'b0, 4, ST_FETCH, ST_DECODE, ST_EXE_R, ST_R_WB, ST_RST,
            e_f, e_d, e_er10, e_rwb, '0);
        add("or",   6'h00, 6'h25, 1'b0, 4, ST_FETCH, ST_DECODE, ST_EXE_R, ST_R_WB, ST_RST,
            e_f, e_d, e_er11, e_rwb, '0);
        add("ori",  6'h0D, 6'h25, 1'b0, 4, ST_FETCH, ST_DECODE, ST_EXE_I, ST_I_WB, ST_RST,
            e_f, e_d, e_ei_ori, e_iwb, '0);
        add("lui",  6'h0F, 6'h00, 1'b0, 4, ST_FETCH, ST_DECODE, ST_EXE_I, ST_I_WB, ST_RST,
            e_f, e_d, e_ei_lui, e_iwb, '0);
        add("lw",   6'h23, 6'h00, 1'b0, 5, ST_FETCH, ST_DECODE, ST_MEM_ADR, ST_MEM_RD, ST_MEM_WB,
            e_f, e_d, e_ma, e_mr, e_mwb);
        add("sw",   6'h2B, 6'h00, 1'b0, 4, ST_FETCH, ST_DECODE, ST_MEM_ADR, ST_MEM_WR, ST_RST,
            e_f, e_d, e_ma, e_mwr, '0);
        add("beq_z1", 6'h04, 6'h00, 1'b1, 3, ST_FETCH, ST_DECODE, ST_BRANCH, ST_RST, ST_RST,
            e_f, e_d, e_br1, '0, '0);
        add("beq_z0", 6'h04, 6'h00, 1'b0, 3, ST_FETCH, ST_DECODE, ST_BRANCH, ST_RST, ST_RST,
            e_f, e_d, e_br0, '0, '0);
        add("j",    6'h02, 6'h00, 1'b0, 3, ST_FETCH, ST_DECODE, ST_JUMP, ST_RST, ST_RST,
            e_f, e_d, e_jmp, '0, '0);
        add("ill_op3f", 6'h3F, 6'h00, 1'b0, 2, ST_FETCH, ST_DECODE, ST_RST, ST_RST, ST_RST,
            e_f, e_dill, '0, '0, '0);
        add("ill_fn2a", 6'h00, 6'h2A, 1'b0, 2, ST_FETCH, ST_DECODE, ST_RST, ST_RST, ST_RST,
            e_f, e_dill, '0, '0, '0);
`ifdef MC_CTRL_JAL_EN
        add("jal",  6'h03, 6'h00, 1'b0, 3, ST_FETCH, ST_DECODE, ST_JAL, ST_RST, ST_RST,
            e_f, e_d, e_jal, '0, '0);
`else
        add("jal_ill", 6'h03, 6'h00, 1'b0, 2, ST_FETCH, ST_DECODE, ST_RST, ST_RST, ST_RST,
            e_f, e_dill, '0, '0, '0);
`endif

        repeat (3) begin
            @(negedge clk);
            check("reset_hold", ST_RST, '0);
        end
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            bus.Op       = tbl[i].op;
            bus.Funct    = tbl[i].funct;
            bus.ALU_Zero = tbl[i].zero;
            for (int c = 0; c < tbl[i].len; c++) begin
                @(negedge clk);
                check($sformatf("%s_c%0d", tbl[i].name, c), tbl[i].path[c], tbl[i].outs[c]);
                @(posedge clk);
                #1;
            end
        end
        check("back_to_fetch", ST_FETCH, e_f);

        // ALU_Zero is used combinationally in BRANCH.
        bus.Op       = 6'h04;
        bus.Funct    = 6'h00;
        bus.ALU_Zero = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("br_zero_low", ST_BRANCH, e_br0);
        bus.ALU_Zero = 1'b1;
        #1 check("br_zero_rise", ST_BRANCH, e_br1);
        @(posedge clk);
        #1 check("br_return", ST_FETCH, e_f);
        bus.ALU_Zero = 1'b0;

        // Reset dropped inside MEM_WR must kill MemWrite without waiting for a clock.
        bus.Op = 6'h2B;
        repeat (3) @(posedge clk);
        #1 check("sw_memwr", ST_MEM_WR, e_mwr);
        #2 rst_n = 1'b0;
        #1 check("abort_memwr", ST_RST, '0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1 check("release_fetch", ST_FETCH, e_f);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
